clint_ctrl: RTL and testbench

CLINT_CTRL -- requirements
Module: clint_ctrl

---
 rtl/clint_ctrl_if.sv | 39 +++
 rtl/clint_ctrl.sv | 138 +++++++++++++
 tb/tb_clint_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/clint_ctrl_if.sv
// Bundle between the pipeline/CSR file and the trap controller.
// master = pipeline side driving instruction/CSR state, slave = clint_ctrl.
interface clint_ctrl_if;
    logic        inst_valid_i;
    logic [63:0] inst_pc_i;
    logic        ecall_i;
    logic        mret_i;
    logic        global_int_en_i;
    logic        mtime_int_en_i;
    logic        mtime_int_pend_i;
    logic [63:0] csr_mtvec_i;
    logic [63:0] csr_mepc_i;
    logic [63:0] csr_mstatus_i;
    logic        mepc_wen_o;
    logic [63:0] mepc_wdata_o;
    logic        mcause_wen_o;
    logic [63:0] mcause_wdata_o;
    logic        mstatus_wen_o;
    logic [63:0] mstatus_wdata_o;
    logic        hold_o;
    logic        redirect_o;
    logic [63:0] redirect_pc_o;

    modport slave (
        input  inst_valid_i, inst_pc_i, ecall_i, mret_i,
        input  global_int_en_i, mtime_int_en_i, mtime_int_pend_i,
        input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        output mepc_wen_o, mepc_wdata_o, mcause_wen_o, mcause_wdata_o,
        output mstatus_wen_o, mstatus_wdata_o, hold_o, redirect_o, redirect_pc_o
    );

    modport master (
        output inst_valid_i, inst_pc_i, ecall_i, mret_i,
        output global_int_en_i, mtime_int_en_i, mtime_int_pend_i,
        output csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        input  mepc_wen_o, mepc_wdata_o, mcause_wen_o, mcause_wdata_o,
        input  mstatus_wen_o, mstatus_wdata_o, hold_o, redirect_o, redirect_pc_o
    );
endinterface

// File: rtl/clint_ctrl.sv
// Machine-mode trap/MRET sequencer: event -> CSR write (+1) -> redirect (+2) -> idle (+3).
// Optional CLINT_VECTORED_EN: vectored interrupt targets when mtvec[1:0]==2'b01.
module clint_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    clint_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, TRAP_CSR, MRET_CSR, REDIRECT} state_e;

    localparam logic [63:0] CAUSE_MTI   = {1'b1, 63'd7};
    localparam logic [63:0] CAUSE_ECALL = 64'd11;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] cause_q, cause_d;
    logic        mret_q, mret_d;
    logic        irq_take;
    logic [63:0] trap_base, trap_tgt, mst_trap, mst_mret;

    assign irq_take = bus.global_int_en_i & bus.mtime_int_en_i & bus.mtime_int_pend_i;

    always_comb begin
        trap_base = {bus.csr_mtvec_i[63:2], 2'b00};
`ifdef CLINT_VECTORED_EN
        if (bus.csr_mtvec_i[1:0] == 2'b01 && cause_q[63])
            trap_tgt = trap_base + {cause_q[61:0], 2'b00};
        else
            trap_tgt = trap_base;
`else
        trap_tgt = trap_base;
`endif
    end

`ifndef CLINT_VECTORED_EN
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^bus.csr_mtvec_i[1:0];
`endif

    // Trap entry stacks MIE into MPIE; MRET restores it. MPP is always M-mode.
    always_comb begin
        mst_trap        = bus.csr_mstatus_i;
        mst_trap[7]     = bus.csr_mstatus_i[3];
        mst_trap[3]     = 1'b0;
        mst_trap[12:11] = 2'b11;
        mst_mret        = bus.csr_mstatus_i;
        mst_mret[3]     = bus.csr_mstatus_i[7];
        mst_mret[7]     = 1'b1;
        mst_mret[12:11] = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            mret_q  <= mret_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        pc_d                = pc_q;
        cause_d             = cause_q;
        mret_d              = mret_q;
        bus.mepc_wen_o      = 1'b0;
        bus.mepc_wdata_o    = '0;
        bus.mcause_wen_o    = 1'b0;
        bus.mcause_wdata_o  = '0;
        bus.mstatus_wen_o   = 1'b0;
        bus.mstatus_wdata_o = '0;
        bus.hold_o          = 1'b0;
        bus.redirect_o      = 1'b0;
        bus.redirect_pc_o   = '0;
        case (state_q)
            IDLE: begin
                if (bus.inst_valid_i) begin
                    if (irq_take) begin
                        pc_d       = bus.inst_pc_i;
                        cause_d    = CAUSE_MTI;
                        mret_d     = 1'b0;
                        state_d    = TRAP_CSR;
                        bus.hold_o = 1'b1;
                    end else if (bus.ecall_i) begin
                        pc_d       = bus.inst_pc_i;
                        cause_d    = CAUSE_ECALL;
                        mret_d     = 1'b0;
                        state_d    = TRAP_CSR;
                        bus.hold_o = 1'b1;
                    end else if (bus.mret_i) begin
                        mret_d     = 1'b1;
                        state_d    = MRET_CSR;
                        bus.hold_o = 1'b1;
                    end
                end
            end
            TRAP_CSR: begin
                bus.hold_o          = 1'b1;
                bus.mepc_wen_o      = 1'b1;
                bus.mepc_wdata_o    = pc_q;
                bus.mcause_wen_o    = 1'b1;
                bus.mcause_wdata_o  = cause_q;
                bus.mstatus_wen_o   = 1'b1;
                bus.mstatus_wdata_o = mst_trap;
                state_d             = REDIRECT;
            end
            MRET_CSR: begin
                bus.hold_o          = 1'b1;
                bus.mstatus_wen_o   = 1'b1;
                bus.mstatus_wdata_o = mst_mret;
                state_d             = REDIRECT;
            end
            REDIRECT: begin
                bus.hold_o        = 1'b1;
                bus.redirect_o    = 1'b1;
                bus.redirect_pc_o = mret_q ? bus.csr_mepc_i : trap_tgt;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A reset cycle must never let a half-finished CSR write or redirect escape.
        if (!rst_n) begin
            bus.mepc_wen_o      = 1'b0;
            bus.mepc_wdata_o    = '0;
            bus.mcause_wen_o    = 1'b0;
            bus.mcause_wdata_o  = '0;
            bus.mstatus_wen_o   = 1'b0;
            bus.mstatus_wdata_o = '0;
            bus.hold_o          = 1'b0;
            bus.redirect_o      = 1'b0;
            bus.redirect_pc_o   = '0;
        end
    end
endmodule

// File: tb/tb_clint_ctrl.sv
// Bench for clint_ctrl: vector table of trap/MRET events plus hand sequences,
// expected CSR writes and redirects queued with their cycle and checked on negedge.
module tb_clint_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    clint_ctrl_if bus();

    clint_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [63:0] C_MTI   = {1'b1, 63'd7};
    localparam logic [63:0] C_ECALL = 64'd11;
`ifdef CLINT_VECTORED_EN
    localparam logic [63:0] VEC_TGT = 64'h8000_011C;
`else
    localparam logic [63:0] VEC_TGT = 64'h8000_0100;
`endif

    typedef struct packed {
        logic        mepc_wen;
        logic [63:0] mepc_wd;
        logic        mcause_wen;
        logic [63:0] mcause_wd;
        logic        mst_wen;
        logic [63:0] mst_wd;
        logic        redir;
        logic [63:0] rpc;
    } out_t;

    typedef struct {
        int   at;
        out_t o;
    } exp_t;

    typedef struct {
        logic        pend, gie, mtie, ecall, mret;
        logic [63:0] pc, mtvec, mstatus, mepc;
        logic [63:0] cause, mst_w, tgt;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   cyc = 0;
    int   rd_idx = 0;
    int   checks = 0;
    int   errors = 0;
    logic exp_hold = 1'b0;
    logic done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        out_t act;
        act.mepc_wen   = bus.mepc_wen_o;
        act.mepc_wd    = bus.mepc_wdata_o;
        act.mcause_wen = bus.mcause_wen_o;
        act.mcause_wd  = bus.mcause_wdata_o;
        act.mst_wen    = bus.mstatus_wen_o;
        act.mst_wd     = bus.mstatus_wdata_o;
        act.redir      = bus.redirect_o;
        act.rpc        = bus.redirect_pc_o;
        checks++;
        if (bus.hold_o !== exp_hold) begin
            errors++;
            $display("FAIL hold cyc=%0d got=%b exp=%b", cyc, bus.hold_o, exp_hold);
        end
        checks++;
        if (act.mepc_wen || act.mcause_wen || act.mst_wen || act.redir) begin
            if (rd_idx < exp_q.size()) begin
                if (act !== exp_q[rd_idx].o || cyc != exp_q[rd_idx].at) begin
                    errors++;
                    $display("FAIL event#%0d cyc=%0d got=%h exp_cyc=%0d exp=%h",
                             rd_idx, cyc, act, exp_q[rd_idx].at, exp_q[rd_idx].o);
                end
                rd_idx++;
            end else begin
                errors++;
                $display("FAIL unexpected_output cyc=%0d got=%h exp=none", cyc, act);
            end
        end else if (act !== '0) begin
            errors++;
            $display("FAIL idle_outputs cyc=%0d got=%h exp=0", cyc, act);
        end
        if (done) begin
            checks++;
            if (rd_idx != exp_q.size()) begin
                errors++;
                $display("FAIL missing_events got=%0d exp=%0d", rd_idx, exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic idle_inputs();
        bus.inst_valid_i     = 1'b0;
        bus.ecall_i          = 1'b0;
        bus.mret_i           = 1'b0;
        bus.mtime_int_pend_i = 1'b0;
    endtask

    task automatic push_trap(input logic [63:0] pc, input logic [63:0] cause,
                             input logic [63:0] mst_w, input logic [63:0] tgt);
        exp_t e;
        e.at = cyc + 1;
        e.o = '{1'b1, pc, 1'b1, cause, 1'b1, mst_w, 1'b0, 64'd0};
        exp_q.push_back(e);
        e.at = cyc + 2;
        e.o = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, tgt};
        exp_q.push_back(e);
    endtask

    task automatic push_mret(input logic [63:0] mst_w, input logic [63:0] tgt);
        exp_t e;
        e.at = cyc + 1;
        e.o = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b1, mst_w, 1'b0, 64'd0};
        exp_q.push_back(e);
        e.at = cyc + 2;
        e.o = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, tgt};
        exp_q.push_back(e);
    endtask

    task automatic step(input logic h);
        @(posedge clk);
        #1;
        exp_hold = h;
    endtask

    task automatic run_vector(input vec_t v);
        step(1'b1);
        bus.inst_valid_i     = 1'b1;
        bus.inst_pc_i        = v.pc;
        bus.ecall_i          = v.ecall;
        bus.mret_i           = v.mret;
        bus.global_int_en_i  = v.gie;
        bus.mtime_int_en_i   = v.mtie;
        bus.mtime_int_pend_i = v.pend;
        bus.csr_mtvec_i      = v.mtvec;
        bus.csr_mstatus_i    = v.mstatus;
        bus.csr_mepc_i       = v.mepc;
        if ((v.pend && v.gie && v.mtie) || v.ecall)
            push_trap(v.pc, v.cause, v.mst_w, v.tgt);
        else
            push_mret(v.mst_w, v.tgt);
        step(1'b1);
        idle_inputs();
        step(1'b1);
        step(1'b0);
    endtask

    initial begin
        //          pend  gie   mtie  ecall mret  pc                     mtvec                  mstatus                mepc                   cause    mst_w                  tgt
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0040,         64'h8000_0100,         64'h1888,              64'h0,                 C_MTI,   64'h1880,              64'h8000_0100};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h8000_0200,         64'h8000_0100,         64'h1800,              64'h0,                 C_ECALL, 64'h1800,              64'h8000_0100};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0500,         64'h8000_0100,         64'h1880,              64'h8000_0044,         64'h0,   64'h1888,              64'h8000_0044};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h8000_0600,         64'h8000_0101,         64'h0008,              64'h0,                 C_ECALL, 64'h1880,              64'h8000_0100};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0040,         64'h8000_0101,         64'h0000,              64'h0,                 C_MTI,   64'h1800,              VEC_TGT};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0700,         64'h8000_0100,         64'h0000,              64'h1234_5678_9ABC_DEF2, 64'h0, 64'h1880,              64'h1234_5678_9ABC_DEF2};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0800,         64'h8000_0100,         64'h0080,              64'h1000_0000,         64'h0,   64'h1888,              64'h1000_0000};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,             C_ECALL, 64'hFFFF_FFFF_FFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFFC};

        rst_n = 1'b0;
        idle_inputs();
        bus.inst_pc_i       = '0;
        bus.global_int_en_i = 1'b0;
        bus.mtime_int_en_i  = 1'b0;
        bus.csr_mtvec_i     = '0;
        bus.csr_mepc_i      = '0;
        bus.csr_mstatus_i   = '0;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        step(1'b0);

        for (int i = 0; i < 8; i++) run_vector(vecs[i]);

        // Events ignored without inst_valid_i, and a valid instruction with no event.
        step(1'b0);
        bus.global_int_en_i = 1'b1; bus.mtime_int_en_i = 1'b1;
        bus.mtime_int_pend_i = 1'b1; bus.ecall_i = 1'b1; bus.mret_i = 1'b1;
        step(1'b0);
        idle_inputs();
        bus.inst_valid_i = 1'b1;
        step(1'b0);
        idle_inputs();

        // Interrupt beats a same-cycle ECALL; the held ECALL is only taken back in IDLE.
        step(1'b1);
        bus.csr_mtvec_i = 64'h8000_0100; bus.csr_mstatus_i = 64'h1888;
        bus.global_int_en_i = 1'b1; bus.mtime_int_en_i = 1'b1; bus.mtime_int_pend_i = 1'b1;
        bus.inst_valid_i = 1'b1; bus.ecall_i = 1'b1; bus.inst_pc_i = 64'h8000_0300;
        push_trap(64'h8000_0300, C_MTI, 64'h1880, 64'h8000_0100);
        step(1'b1);
        bus.mtime_int_pend_i = 1'b0; bus.inst_pc_i = 64'h8000_0304;
        step(1'b1);
        bus.inst_pc_i = 64'h8000_0308;
        step(1'b1);
        bus.inst_pc_i = 64'h8000_030C;
        push_trap(64'h8000_030C, C_ECALL, 64'h1880, 64'h8000_0100);
        step(1'b1);
        idle_inputs();
        step(1'b1);
        step(1'b0);

        // Reset during TRAP_CSR: nothing written, no redirect, hold low even with events.
        step(1'b1);
        bus.inst_valid_i = 1'b1; bus.mtime_int_pend_i = 1'b1; bus.inst_pc_i = 64'h8000_0400;
        step(1'b0);
        idle_inputs();
        rst_n = 1'b0;
        step(1'b0);
        bus.inst_valid_i = 1'b1; bus.ecall_i = 1'b1; bus.mtime_int_pend_i = 1'b1;
        step(1'b0);
        idle_inputs();
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        done = 1'b1;
    end
endmodule
